dm_access_ctrl: RTL and testbench

//  Parametrised data-memory access controller for the M stage, sitting between the pipeline and the DM/bridge.

---
 rtl/dm_access_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// ---------------------------------------------------------------------------
// dm_access_ctrl
//   Data-memory access controller for the M stage. Takes one load/store per
//   request and drives the DM/bridge handshake. It produces the lane-aligned
//   address, byte enables and lane-replicated store data. It then sign- or
//   zero-extends the returned lane into a 32-bit result. Misaligned accesses
//   are reported as AdEL/AdES and never reach memory.
//
//   Optional feature macro: DM_TIMEOUT_EN
//     When defined, the controller gives up after TIMEOUT_CYC cycles of
//     mem_req without mem_ack and responds with EXC_DBE.
//     When undefined, it waits indefinitely for mem_ack.
//
// Ports
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_mode         0 none,1 lw,2 lh,3 lhu,4 lb,5 lbu,6 sw,7 sh,8 sb
//   req_addr/wdata   byte address and store data
//   mem_req/we/addr/be/wdata  memory command, held until mem_ack
//   mem_ack/rdata    memory completion and load data
//   rsp_valid        one-cycle result pulse
//   rsp_data         extended load data (0 for stores/exceptions)
//   rsp_exc/code     exception flag and code
// ---------------------------------------------------------------------------
module dm_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int EXC_ADEL    = 4,
  parameter int EXC_ADES    = 5,
  parameter int EXC_DBE     = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_mode,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  output logic [31:0]         rsp_data,
  output logic                rsp_exc,
  output logic [4:0]          rsp_exc_code
);

  localparam int BE_W   = DATA_W / 8;
  localparam int LANE_W = $clog2(BE_W);

  localparam logic [3:0] MODE_LW  = 4'd1;
  localparam logic [3:0] MODE_LH  = 4'd2;
  localparam logic [3:0] MODE_LHU = 4'd3;
  localparam logic [3:0] MODE_LB  = 4'd4;
  localparam logic [3:0] MODE_LBU = 4'd5;
  localparam logic [3:0] MODE_SW  = 4'd6;
  localparam logic [3:0] MODE_SH  = 4'd7;
  localparam logic [3:0] MODE_SB  = 4'd8;

  // access size encoding
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  // request decode
  logic              dec_access;
  logic              dec_store;
  logic              dec_signed;
  logic [1:0]        dec_size;
  logic              dec_misalign;
  logic              accept;
  logic [LANE_W-1:0] req_off;

  // registered access attributes used when the data comes back
  logic [1:0]        size_q;
  logic              signed_q;
  logic [LANE_W-1:0] off_q;

  logic [31:0]       lane_data;
  logic              timeout;

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size,
                                                  input logic [31:0] d);
    case (size)
      SZ_BYTE: return {(DATA_W/8){d[7:0]}};
      SZ_HALF: return {(DATA_W/16){d[15:0]}};
      default: return {(DATA_W/32){d}};
    endcase
  endfunction

  function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] size,
                                                input logic [LANE_W-1:0] off);
    logic [BE_W-1:0] m;
    case (size)
      SZ_BYTE: m = BE_W'(1);
      SZ_HALF: m = BE_W'(3);
      default: m = BE_W'(15);
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] size,
                                         input logic sgn,
                                         input logic [31:0] lane);
    case (size)
      SZ_BYTE: return {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: return {{16{sgn & lane[15]}}, lane[15:0]};
      default: return lane;
    endcase
  endfunction

  always_comb begin
    dec_access = 1'b1;
    dec_store  = 1'b0;
    dec_signed = 1'b0;
    dec_size   = SZ_WORD;
    case (req_mode)
      MODE_LW:  dec_size = SZ_WORD;
      MODE_LH:  begin dec_size = SZ_HALF; dec_signed = 1'b1; end
      MODE_LHU: dec_size = SZ_HALF;
      MODE_LB:  begin dec_size = SZ_BYTE; dec_signed = 1'b1; end
      MODE_LBU: dec_size = SZ_BYTE;
      MODE_SW:  begin dec_size = SZ_WORD; dec_store = 1'b1; end
      MODE_SH:  begin dec_size = SZ_HALF; dec_store = 1'b1; end
      MODE_SB:  begin dec_size = SZ_BYTE; dec_store = 1'b1; end
      default:  dec_access = 1'b0;
    endcase
  end

  assign dec_misalign = ((dec_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                        ((dec_size == SZ_HALF) && req_addr[0]);
  assign req_off      = req_addr[LANE_W-1:0];
  assign accept       = req_valid && (state == IDLE) && dec_access;

  // Shift the addressed lane down to bit 0; the narrower views are taken
  // from its low bits by extend().
  assign lane_data = 32'(mem_rdata >> {off_q, 3'b000});

`ifdef DM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;

  // Cleared while idle so every access starts counting from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the cycle the count would reach the limit; an ack in that same
  // cycle takes priority.
  assign timeout = (state == ACCESS) && !mem_ack &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = dec_misalign ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_req = 1'b1;
        if (mem_ack || timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      size_q       <= SZ_WORD;
      signed_q     <= 1'b0;
      off_q        <= '0;
      rsp_data     <= '0;
      rsp_exc      <= 1'b0;
      rsp_exc_code <= '0;
    end else if (accept) begin
      rsp_data     <= '0;
      rsp_exc      <= dec_misalign;
      rsp_exc_code <= !dec_misalign ? 5'd0 :
                      dec_store     ? 5'(EXC_ADES) : 5'(EXC_ADEL);
      // A misaligned request leaves the memory command untouched.
      if (!dec_misalign) begin
        mem_we    <= dec_store;
        mem_addr  <= {req_addr[ADDR_W-1:LANE_W], LANE_W'(0)};
        mem_be    <= lane_mask(dec_size, req_off);
        mem_wdata <= replicate(dec_size, req_wdata);
        size_q    <= dec_size;
        signed_q  <= dec_signed;
        off_q     <= req_off;
      end
    end else if (state == ACCESS) begin
      if (mem_ack) begin
        rsp_data <= mem_we ? 32'd0 : extend(size_q, signed_q, lane_data);
      end else if (timeout) begin
        rsp_data     <= '0;
        rsp_exc      <= 1'b1;
        rsp_exc_code <= 5'(EXC_DBE);
      end
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid, req_ready;
  logic [3:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_exc;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_exc_code;

  // 64-bit instance
  logic        req_valid64, req_ready64;
  logic [3:0]  req_mode64;
  logic [31:0] req_addr64, req_wdata64;
  logic        mem_req64, mem_we64, mem_ack64;
  logic [31:0] mem_addr64;
  logic [7:0]  mem_be64;
  logic [63:0] mem_wdata64, mem_rdata64;
  logic        rsp_valid64, rsp_exc64;
  logic [31:0] rsp_data64;
  logic [4:0]  rsp_exc_code64;

  dm_access_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
    .rsp_exc_code(rsp_exc_code)
  );

  dm_access_ctrl #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid64), .req_ready(req_ready64), .req_mode(req_mode64),
    .req_addr(req_addr64), .req_wdata(req_wdata64),
    .mem_req(mem_req64), .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_be(mem_be64),
    .mem_wdata(mem_wdata64), .mem_ack(mem_ack64), .mem_rdata(mem_rdata64),
    .rsp_valid(rsp_valid64), .rsp_data(rsp_data64), .rsp_exc(rsp_exc64),
    .rsp_exc_code(rsp_exc_code64)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] mwdata;
  } vec_t;

  vec_t vecs[16];

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_addr;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    @(negedge clk);
    req_valid = 1'b1; req_mode = v.mode; req_addr = v.addr; req_wdata = v.wdata;
    mem_ack = 1'b0;
    chk({v.name, ".ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    if (!v.exc) begin
      chk({v.name, ".mem_req"}, mem_req, 1'b1);
      chk({v.name, ".mem_we"}, mem_we, v.we);
      chk({v.name, ".mem_addr"}, mem_addr, exp_addr);
      if (v.we) begin
        chk({v.name, ".mem_be"}, mem_be, v.be);
        chk({v.name, ".mem_wdata"}, mem_wdata, v.mwdata);
      end
      for (int d = 0; d < v.delay; d++) begin
        // a competing request while busy must not disturb the command
        req_valid = 1'b1; req_mode = 4'd6; req_addr = 32'h0000_0F0C; req_wdata = 32'h5555_5555;
        mem_rdata = 32'hDEAD_DEAD;
        @(negedge clk);
        chk({v.name, ".hold_req"}, mem_req, 1'b1);
        chk({v.name, ".hold_rsp"}, rsp_valid, 1'b0);
        chk({v.name, ".hold_ready"}, req_ready, 1'b0);
        chk({v.name, ".hold_addr"}, mem_addr, exp_addr);
        if (v.we) chk({v.name, ".hold_wdata"}, mem_wdata, v.mwdata);
      end
      req_valid = 1'b0;
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0BAD_F00D;
      chk({v.name, ".mem_req_drop"}, mem_req, 1'b0);
    end else begin
      chk({v.name, ".no_mem_req"}, mem_req, 1'b0);
    end
    chk({v.name, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({v.name, ".rsp_data"}, rsp_data, v.data);
    chk({v.name, ".rsp_exc"}, rsp_exc, v.exc);
    chk({v.name, ".rsp_code"}, rsp_exc_code, v.code);
    @(negedge clk);
    chk({v.name, ".rsp_pulse"}, rsp_valid, 1'b0);
    chk({v.name, ".idle_ready"}, req_ready, 1'b1);
    chk({v.name, ".idle_mem_req"}, mem_req, 1'b0);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{"lb_02",    4'd4, 32'h1002, 32'h0,        32'hF2345678, 0, 1'b0, 5'd0, 32'h00000034, 1'b0, 4'h0, 32'h0};
    vecs[1]  = '{"lbu_02",   4'd5, 32'h1002, 32'h0,        32'hF2345678, 0, 1'b0, 5'd0, 32'h00000034, 1'b0, 4'h0, 32'h0};
    vecs[2]  = '{"lh_02",    4'd2, 32'h1002, 32'h0,        32'hF2345678, 0, 1'b0, 5'd0, 32'hFFFFF234, 1'b0, 4'h0, 32'h0};
    vecs[3]  = '{"lhu_02",   4'd3, 32'h1002, 32'h0,        32'hF2345678, 1, 1'b0, 5'd0, 32'h0000F234, 1'b0, 4'h0, 32'h0};
    vecs[4]  = '{"lb_03",    4'd4, 32'h1003, 32'h0,        32'hF2345678, 0, 1'b0, 5'd0, 32'hFFFFFFF2, 1'b0, 4'h0, 32'h0};
    vecs[5]  = '{"lbu_03",   4'd5, 32'h1003, 32'h0,        32'hF2345678, 0, 1'b0, 5'd0, 32'h000000F2, 1'b0, 4'h0, 32'h0};
    vecs[6]  = '{"lw_00",    4'd1, 32'h2000, 32'h0,        32'h89ABCDEF, 2, 1'b0, 5'd0, 32'h89ABCDEF, 1'b0, 4'h0, 32'h0};
    vecs[7]  = '{"lb_dly5",  4'd4, 32'h1000, 32'h0,        32'h12345680, 5, 1'b0, 5'd0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0};
    vecs[8]  = '{"sb_01",    4'd8, 32'h4001, 32'h000000AB, 32'hFFFFFFFF, 1, 1'b0, 5'd0, 32'h0, 1'b1, 4'b0010, 32'hABABABAB};
    vecs[9]  = '{"sh_02",    4'd7, 32'h4002, 32'h1234BEEF, 32'hFFFFFFFF, 0, 1'b0, 5'd0, 32'h0, 1'b1, 4'b1100, 32'hBEEFBEEF};
    vecs[10] = '{"sw_dly5",  4'd6, 32'h4004, 32'hDEADBEEF, 32'hFFFFFFFF, 5, 1'b0, 5'd0, 32'h0, 1'b1, 4'b1111, 32'hDEADBEEF};
    vecs[11] = '{"lw_06",    4'd1, 32'h5006, 32'h0,        32'h0,        0, 1'b1, 5'd4, 32'h0, 1'b0, 4'h0, 32'h0};
    vecs[12] = '{"sh_01",    4'd7, 32'h5001, 32'h1234,     32'h0,        0, 1'b1, 5'd5, 32'h0, 1'b0, 4'h0, 32'h0};
    vecs[13] = '{"lh_03",    4'd2, 32'h5003, 32'h0,        32'h0,        0, 1'b1, 5'd4, 32'h0, 1'b0, 4'h0, 32'h0};
    vecs[14] = '{"sw_02",    4'd6, 32'h5002, 32'h99,       32'h0,        0, 1'b1, 5'd5, 32'h0, 1'b0, 4'h0, 32'h0};
    vecs[15] = '{"lhu_00",   4'd3, 32'h6000, 32'h0,        32'h00018765, 0, 1'b0, 5'd0, 32'h00008765, 1'b0, 4'h0, 32'h0};

    req_valid = 0; req_mode = 0; req_addr = 0; req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    req_valid64 = 0; req_mode64 = 0; req_addr64 = 0; req_wdata64 = 0; mem_ack64 = 0; mem_rdata64 = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.ready", req_ready, 1'b1);
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_be", mem_be, 4'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_data", rsp_data, 32'h0);
    chk("rst.rsp_exc", rsp_exc, 1'b0);
    chk("rst.rsp_code", rsp_exc_code, 5'd0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // mode none and reserved modes: accepted silently, no response
    for (int m = 0; m < 2; m++) begin
      @(negedge clk);
      req_valid = 1'b1; req_mode = (m == 0) ? 4'd0 : 4'd12; req_addr = 32'h7777;
      @(negedge clk);
      req_valid = 1'b0;
      chk("none.mem_req", mem_req, 1'b0);
      chk("none.rsp_valid", rsp_valid, 1'b0);
      chk("none.ready", req_ready, 1'b1);
      @(negedge clk);
      chk("none.rsp_valid2", rsp_valid, 1'b0);
    end

    // ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack.rsp_valid", rsp_valid, 1'b0);
    chk("idle_ack.ready", req_ready, 1'b1);

    // request held during RESP is only accepted in the following idle cycle
    @(negedge clk);
    req_valid = 1'b1; req_mode = 4'd1; req_addr = 32'h6002;
    @(negedge clk);
    chk("b2b.exc_rsp", rsp_valid, 1'b1);
    chk("b2b.exc_code", rsp_exc_code, 5'd4);
    chk("b2b.resp_not_ready", req_ready, 1'b0);
    req_mode = 4'd8; req_addr = 32'h7003; req_wdata = 32'h0000_0011;
    @(negedge clk);
    chk("b2b.idle_ready", req_ready, 1'b1);
    chk("b2b.idle_no_req", mem_req, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b.mem_req", mem_req, 1'b1);
    chk("b2b.mem_be", mem_be, 4'b1000);
    chk("b2b.mem_wdata", mem_wdata, 32'h1111_1111);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("b2b.rsp_valid", rsp_valid, 1'b1);
    chk("b2b.rsp_exc", rsp_exc, 1'b0);
    @(negedge clk);

    // reset during ACCESS
    @(negedge clk);
    req_valid = 1'b1; req_mode = 4'd1; req_addr = 32'h8000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstacc.mem_req_pre", mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstacc.mem_req", mem_req, 1'b0);
    chk("rstacc.ready", req_ready, 1'b1);
    chk("rstacc.rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rstacc.late_ack", rsp_valid, 1'b0);
    @(negedge clk);
    chk("rstacc.late_ack2", rsp_valid, 1'b0);
    chk("rstacc.mem_req2", mem_req, 1'b0);

    // long wait without ack
    @(negedge clk);
    req_valid = 1'b1; req_mode = 4'd1; req_addr = 32'h9000;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
`ifdef DM_TIMEOUT_EN
    // default limit: 255 cycles of mem_req, then a bus-error response
    for (int c = 0; c < 254; c++) begin
      @(negedge clk);
      if (rsp_valid || !mem_req) seen++;
    end
    chk("wait.early_end", seen, 0);
    @(negedge clk);
    chk("tmo.rsp_valid", rsp_valid, 1'b1);
    chk("tmo.rsp_exc", rsp_exc, 1'b1);
    chk("tmo.code", rsp_exc_code, 5'd7);
    chk("tmo.data", rsp_data, 32'h0);
    chk("tmo.mem_req", mem_req, 1'b0);
    @(negedge clk);
`else
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rsp_valid || !mem_req) seen++;
    end
    chk("wait.early_end", seen, 0);
    mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("wait.rsp_valid", rsp_valid, 1'b1);
    chk("wait.rsp_exc", rsp_exc, 1'b0);
    chk("wait.rsp_data", rsp_data, 32'h0102_0304);
    @(negedge clk);
`endif

    // 64-bit bus: lh at offset 6
    @(negedge clk);
    req_valid64 = 1'b1; req_mode64 = 4'd2; req_addr64 = 32'h1006;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("w64_lh.mem_req", mem_req64, 1'b1);
    chk("w64_lh.mem_addr", mem_addr64, 32'h1000);
    chk("w64_lh.mem_we", mem_we64, 1'b0);
    mem_ack64 = 1'b1; mem_rdata64 = 64'h8001_0000_0000_0000;
    @(negedge clk);
    mem_ack64 = 1'b0; mem_rdata64 = '0;
    chk("w64_lh.rsp_valid", rsp_valid64, 1'b1);
    chk("w64_lh.rsp_data", rsp_data64, 32'hFFFF_8001);
    @(negedge clk);

    // 64-bit bus: sb at offset 5
    @(negedge clk);
    req_valid64 = 1'b1; req_mode64 = 4'd8; req_addr64 = 32'h2005; req_wdata64 = 32'h0000_005A;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("w64_sb.mem_be", mem_be64, 8'h20);
    chk("w64_sb.mem_wdata", mem_wdata64, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("w64_sb.mem_we", mem_we64, 1'b1);
    mem_ack64 = 1'b1; mem_rdata64 = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_ack64 = 1'b0;
    chk("w64_sb.rsp_data", rsp_data64, 32'h0);
    @(negedge clk);

    // 64-bit bus: lw from upper word
    @(negedge clk);
    req_valid64 = 1'b1; req_mode64 = 4'd1; req_addr64 = 32'h3004;
    @(negedge clk);
    req_valid64 = 1'b0;
    chk("w64_lw.mem_addr", mem_addr64, 32'h3000);
    mem_ack64 = 1'b1; mem_rdata64 = 64'hCAFE_BABE_1234_5678;
    @(negedge clk);
    mem_ack64 = 1'b0;
    chk("w64_lw.rsp_data", rsp_data64, 32'hCAFE_BABE);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
